shift_piso: RTL and testbench

//  Parallel-in/serial-out unloader; inverse of the shift tap register.

---
 rtl/shift_pkg.sv | 14 +
 rtl/shift_piso.sv | 63 ++++++
 tb/tb_shift_piso.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared types and sizing helpers for the parallel-in/serial-out unloader.
package shift_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } shift_piso_state_e;

    // Index width never collapses to zero bits, even for single-word vectors.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/shift_piso.sv
// Unloads a depth_p-word vector as a word stream, highest index first, lowest (last_o) final.
// Latency: first word valid the cycle after accept; sustained 1 word/cycle, back-to-back vectors without bubbles.
// Backpressure: ready_i low holds the current word; ready_o only rises in IDLE or on the last word's beat (comb ready_i path).
module shift_piso
    import shift_pkg::*;
#(
    parameter int width_p = 8,
    parameter int depth_p = 3
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [width_p-1:0]            data_i [depth_p-1:0],
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [width_p-1:0]            data_o,
    output logic [idx_width(depth_p)-1:0] idx_o,
    output logic                          last_o
);

    localparam int              IdxW   = idx_width(depth_p);
    localparam logic [IdxW-1:0] IdxMax = IdxW'(depth_p - 1);
    localparam logic [IdxW-1:0] IdxOne = IdxW'(1);

    shift_piso_state_e   state;
    logic [width_p-1:0]  vec_q [depth_p-1:0];
    logic [IdxW-1:0]     idx;
    logic                accept;
    logic                beat;

    assign valid_o = (state == SHIFT);
    assign last_o  = valid_o && (idx == '0);
    assign ready_o = reset_ni && ((state == IDLE) || (last_o && ready_i));
    assign accept  = valid_i && ready_o;
    assign beat    = valid_o && ready_i;
    assign idx_o   = idx;
    assign data_o  = vec_q[idx];

    // An accept while shifting can only coincide with the final beat, so it reloads in place.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= IDLE;
            idx   <= '0;
            for (int i = 0; i < depth_p; i++) begin
                vec_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                vec_q <= data_i;
                idx   <= IdxMax;
                state <= SHIFT;
            end else if (beat) begin
                if (idx != '0) begin
                    idx <= idx - IdxOne;
                end else begin
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_piso.sv
// Scoreboarded bench for shift_piso: directed scenarios plus random vectors and random backpressure.
module tb_shift_piso;

    localparam int W = 8;
    localparam int D = 3;

    typedef struct {
        logic [W-1:0] dat;
        int           idx;
        bit           last;
    } word_t;

    logic         clk = 1'b0;
    logic         reset_ni = 1'b0;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] data_i [D-1:0];
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] data_o;
    logic [1:0]   idx_o;
    logic         last_o;

    logic         v1;
    logic         r1o;
    logic [W-1:0] d1 [0:0];
    logic         vo1;
    logic         r1;
    logic [W-1:0] do1;
    logic [0:0]   idx1;
    logic         last1;

    int checks = 0;
    int failures = 0;
    bit rand_rdy = 0;
    bit run1 = 0;
    bit acc1 = 0;

    word_t        exp_q[$];
    logic [23:0]  vec_hist[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] sr [3];

    always #5 clk = ~clk;

    shift_piso #(.width_p(W), .depth_p(D)) dut (
        .clk_i(clk), .reset_ni(reset_ni), .valid_i(valid_i), .ready_o(ready_o),
        .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
        .idx_o(idx_o), .last_o(last_o)
    );

    shift_piso #(.width_p(W), .depth_p(1)) dut1 (
        .clk_i(clk), .reset_ni(reset_ni), .valid_i(v1), .ready_o(r1o),
        .data_i(d1), .valid_o(vo1), .ready_i(r1), .data_o(do1),
        .idx_o(idx1), .last_o(last1)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    // Monitor for the depth-3 instance: flow-control rules, word order, stall hold, round trip.
    initial begin
        bit           have_prev = 0;
        logic         pv = 0, pr = 0;
        logic [W-1:0] pd = '0;
        logic [1:0]   pi = '0;
        forever begin
            @(negedge clk);
            #4;
            if (!reset_ni) begin
                have_prev = 0;
                continue;
            end
            chk("valid_o_model", valid_o, exp_q.size() != 0);
            chk("ready_o_model", ready_o, (exp_q.size() == 0) || (exp_q.size() == 1 && ready_i));
            if (have_prev && pv && !pr) begin
                chk("stall_valid", valid_o, 1);
                chk("stall_data", data_o, pd);
                chk("stall_idx", idx_o, pi);
            end
            if (valid_o && exp_q.size() != 0) begin
                chk("word_data", data_o, exp_q[0].dat);
                chk("word_idx", idx_o, exp_q[0].idx);
                chk("word_last", last_o, exp_q[0].last);
                if (ready_i) begin
                    sr[2] = sr[1];
                    sr[1] = sr[0];
                    sr[0] = data_o;
                    if (exp_q[0].last && vec_hist.size() != 0)
                        chk("round_trip_taps", {sr[2], sr[1], sr[0]}, vec_hist.pop_front());
                    void'(exp_q.pop_front());
                end
            end
            if (valid_i && ready_o) begin
                for (int k = D - 1; k >= 0; k--)
                    exp_q.push_back('{dat: data_i[k], idx: k, last: (k == 0)});
                vec_hist.push_back({data_i[2], data_i[1], data_i[0]});
            end
            have_prev = 1;
            pv = valid_o;
            pr = ready_i;
            pd = data_o;
            pi = idx_o;
        end
    end

    always @(negedge clk) if (rand_rdy) ready_i = 1'($urandom_range(0, 1));

    // Depth-1 instance: random source honouring hold-until-ready, random sink.
    always @(negedge clk) begin
        if (run1) begin
            if (!v1 || acc1) begin
                v1 = ($urandom_range(0, 3) != 0);
                d1[0] = W'($urandom);
            end
            r1 = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #4;
            acc1 = 0;
            if (run1 && reset_ni) begin
                chk("d1_valid_model", vo1, q1.size() != 0);
                chk("d1_ready", r1o, !vo1 || r1);
                if (vo1 && q1.size() != 0) begin
                    chk("d1_data", do1, q1[0]);
                    chk("d1_idx", idx1, 0);
                    chk("d1_last", last1, 1);
                    if (r1) void'(q1.pop_front());
                end
                acc1 = v1 && r1o;
                if (acc1) q1.push_back(d1[0]);
            end
        end
    end

    task automatic send_vec(input logic [23:0] v);
        bit got = 0;
        valid_i = 1'b1;
        for (int k = 0; k < D; k++) data_i[k] = v[k*W +: W];
        for (int t = 0; t < 200 && !got; t++) begin
            #4;
            got = ready_o;
            @(negedge clk);
        end
        valid_i = 1'b0;
        chk("vec_accepted", got, 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int t = 0; t < budget && exp_q.size() != 0; t++) @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        #2 reset_ni = 1'b0;
        #1;
        chk("rst_valid_o", valid_o, 0);
        chk("rst_data_o", data_o, 0);
        chk("rst_ready_o", ready_o, 0);
        chk("rst_idx_o", idx_o, 0);
        chk("rst_last_o", last_o, 0);
        exp_q.delete();
        vec_hist.delete();
        q1.delete();
        @(negedge clk);
        #2 reset_ni = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        valid_i = 0;
        ready_i = 0;
        v1 = 0;
        r1 = 0;
        d1[0] = '0;
        for (int k = 0; k < D; k++) data_i[k] = '0;
        for (int k = 0; k < 3; k++) sr[k] = '0;

        #3;
        chk("init_valid_o", valid_o, 0);
        chk("init_data_o", data_o, 0);
        chk("init_ready_o", ready_o, 0);
        @(negedge clk);
        @(negedge clk);
        #2 reset_ni = 1'b1;
        @(negedge clk);
        run1 = 1;

        // single vector, free-flowing sink
        ready_i = 1;
        send_vec(24'h33_22_11);
        wait_idle(50);

        // back-to-back vectors with valid held
        send_vec(24'h33_22_11);
        send_vec(24'h66_55_44);
        wait_idle(50);

        // two-cycle stall while 22 is presented
        send_vec(24'h33_22_11);
        @(negedge clk);
        ready_i = 0;
        @(negedge clk);
        #1;
        chk("stall_hold_data", data_o, 8'h22);
        chk("stall_hold_idx", idx_o, 1);
        chk("stall_hold_valid", valid_o, 1);
        @(negedge clk);
        ready_i = 1;
        #1;
        chk("stall_hold2_data", data_o, 8'h22);
        @(negedge clk);
        #1;
        chk("stall_resume_data", data_o, 8'h11);
        wait_idle(50);

        // reset mid-vector, then a fresh vector
        send_vec(24'h33_22_11);
        @(negedge clk);
        do_reset();
        send_vec(24'hAA_BB_CC);
        #1;
        chk("post_rst_data", data_o, 8'hAA);
        chk("post_rst_idx", idx_o, 2);
        wait_idle(50);

        // random vectors, random gaps, random backpressure
        rand_rdy = 1;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 3)) @(negedge clk);
            send_vec(24'($urandom));
        end
        wait_idle(1000);
        rand_rdy = 0;
        ready_i = 1;
        run1 = 0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
